// File: rtl/bcd_pkg.sv
// Shared BCD/7-segment definitions: converter state encoding, digit limits and segment codes.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DIG_MAX  = 9;
  localparam int unsigned NIB_CORR = 3;
  localparam int unsigned NIB_THR  = 8;

  // Segment order {a,b,c,d,e,f,g}, active-high; shared with the binary-to-display path.
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

endpackage

// File: rtl/seg7_to_bcd.sv
// Single-digit 7-segment decoder: code -> 4-bit digit plus invalid flag for unknown patterns.
module seg7_to_bcd
  import bcd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit_c,
  output logic       invalid_c
);

  always_comb begin
    digit_c   = 4'd0;
    invalid_c = 1'b0;
    case (seg)
      SEG_0:   digit_c = 4'd0;
      SEG_1:   digit_c = 4'd1;
      SEG_2:   digit_c = 4'd2;
      SEG_3:   digit_c = 4'd3;
      SEG_4:   digit_c = 4'd4;
      SEG_5:   digit_c = 4'd5;
      SEG_6:   digit_c = 4'd6;
      SEG_7:   digit_c = 4'd7;
      SEG_8:   digit_c = 4'd8;
      SEG_9:   digit_c = 4'd9;
      default: invalid_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble, one bit per clock).
// Optional SEG_INPUT_EN: digits come from per-digit 7-segment codes on seg_in instead of bcd_in.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
`ifdef SEG_INPUT_EN
  input  logic [7*DIGITS-1:0]   seg_in,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_t            state, state_d;
  logic [SR_W-1:0]   sreg, sreg_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [BIN_W-1:0]  bin_d;
  logic              err_d, busy_d, done_d;

  logic [BCD_W-1:0]  src_bcd;
  logic              src_bad;
  logic [SR_W-1:0]   shifted, corrected;

`ifdef SEG_INPUT_EN
  logic [DIGITS-1:0] seg_bad;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
    seg7_to_bcd u_dec (
      .seg       (seg_in[7*g +: 7]),
      .digit_c   (src_bcd[4*g +: 4]),
      .invalid_c (seg_bad[g])
    );
  end

  assign src_bad = |seg_bad;
`else
  assign src_bcd = bcd_in;

  always_comb begin
    src_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_in[4*i +: 4] > 4'(DIG_MAX)) src_bad = 1'b1;
    end
  end
`endif

  // One reverse-dabble step: shift right, then pull every BCD nibble >= 8 back by 3.
  always_comb begin
    shifted   = sreg >> 1;
    corrected = shifted;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (shifted[BIN_W + 4*i +: 4] >= 4'(NIB_THR)) begin
        corrected[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'(NIB_CORR);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    sreg_d  = sreg;
    cnt_d   = cnt;
    bin_d   = bin_out;
    err_d   = err;
    case (state)
      IDLE: begin
        if (start) begin
          if (src_bad) begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = DONE;
          end else begin
            sreg_d  = {src_bcd, {BIN_W{1'b0}}};
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sreg_d = corrected;
        cnt_d  = cnt + CNT_W'(1);
        if (cnt == CNT_W'(BIN_W - 1)) begin
          bin_d   = corrected[BIN_W-1:0];
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Datapath and registered outputs follow the next-state decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      cnt     <= '0;
      bin_out <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      sreg    <= sreg_d;
      cnt     <= cnt_d;
      bin_out <= bin_d;
      err     <= err_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed handshake cases plus randomized digits vs. an arithmetic model.
module tb_bcd_to_bin_seq;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 10;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int          LIMIT  = 40;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [BCD_W-1:0]   bcd_in;
  logic [7*DIGITS-1:0] seg_in;
  logic               busy, done, err;
  logic [BIN_W-1:0]   bin_out;

  int total = 0;
  int bad   = 0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
`ifdef SEG_INPUT_EN
    .seg_in  (seg_in),
`endif
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000001;
    endcase
  endfunction

  // Reference: weighted decimal sum; any nibble above 9 is an error with result 0.
  function automatic void model(input logic [BCD_W-1:0] v, output int val, output bit e);
    int w;
    val = 0; e = 0; w = 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (int'(v[4*i +: 4]) > 9) e = 1;
      val += int'(v[4*i +: 4]) * w;
      w *= 10;
    end
    if (e) val = 0;
  endfunction

  task automatic apply(input logic [BCD_W-1:0] v);
    bcd_in = v;
    for (int i = 0; i < int'(DIGITS); i++) seg_in[7*i +: 7] = seg_code(v[4*i +: 4]);
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < LIMIT) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic convert(input logic [BCD_W-1:0] v);
    int exp_v, k;
    bit exp_e;
    model(v, exp_v, exp_e);
    @(negedge clk);
    apply(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_acc", busy, 1);
    wait_done(k);
    check("latency", k, exp_e ? 0 : BIN_W);
    check("err", err, exp_e);
    check("bin", bin_out, exp_v);
    check("busy_done", busy, 1);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("busy_end", busy, 0);
  endtask

  initial begin
    int k, hits;
    logic [BCD_W-1:0] v;
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    seg_in = '0;
    #22;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_bin", bin_out, 0);
    @(negedge clk) rst_n = 1'b1;

    convert(12'h999);
    convert(12'h000);
    convert(12'h512);
    convert(12'h007);
    convert(12'h1A3);
    convert(12'h888);
    convert(12'hF00);
    convert(12'h00C);

    // Start while busy must be ignored.
    @(negedge clk);
    apply(12'h123);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    apply(12'h456);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(k);
    check("ignore_bin", bin_out, 123);
    @(posedge clk); #1;

    // Start held high: next conversion accepted on the first IDLE edge.
    @(negedge clk);
    apply(12'h321);
    start = 1'b1;
    @(posedge clk); #1;
    wait_done(k);
    check("hold_bin1", bin_out, 321);
    apply(12'h654);
    @(posedge clk); #1;
    check("hold_idle", busy, 0);
    @(posedge clk); #1;
    check("hold_acc", busy, 1);
    start = 1'b0;
    wait_done(k);
    check("hold_lat", k, BIN_W);
    check("hold_bin2", bin_out, 654);
    @(posedge clk); #1;

    // Reset mid-conversion aborts without a done pulse.
    @(negedge clk);
    apply(12'h999);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bin", bin_out, 0);
    @(negedge clk) rst_n = 1'b1;
    hits = 0;
    repeat (BIN_W + 3) begin
      @(posedge clk); #1;
      if (done) hits++;
    end
    check("abort_no_done", hits, 0);
    convert(12'h345);

    // Randomized digits, roughly one in six nibbles non-decimal.
    repeat (40) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if ($urandom_range(5) == 0) v[4*i +: 4] = 4'($urandom_range(15, 10));
        else                        v[4*i +: 4] = 4'($urandom_range(9));
      end
      convert(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
